// File: rtl/store_pkg.sv
// Shared types and the byte-lane alignment helper for the store unit.
// Fallback store encodings, only used when processor_defines.sv has not
// already been compiled ahead of this file.
`ifndef SB
`define SB 3'b000
`endif
`ifndef SH
`define SH 3'b001
`endif
`ifndef SW
`define SW 3'b010
`endif
`ifndef STR_NOP
`define STR_NOP 3'b111
`endif

package store_pkg;

  localparam logic [2:0] ST_SB  = `SB;
  localparam logic [2:0] ST_SH  = `SH;
  localparam logic [2:0] ST_SW  = `SW;
  localparam logic [2:0] ST_NOP = `STR_NOP;

  // One queued store. The address field is 32 bits wide, so ADDR_W <= 32.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } st_entry_t;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        misaligned;
  } align_t;

  // True for codes that actually write memory; NOP and undefined codes are dropped.
  function automatic logic is_store(input logic [2:0] ctrl);
    return (ctrl == ST_SB) || (ctrl == ST_SH) || (ctrl == ST_SW);
  endfunction

  // Lane-replicate the data and place the byte enables for the low EA bits.
  function automatic align_t align_store(input logic [2:0] ctrl,
                                         input logic [1:0] ea,
                                         input logic [31:0] data);
    align_t r;
    r = '0;
    if (ctrl == ST_SB) begin
      r.be    = 4'b0001 << ea;
      r.wdata = {4{data[7:0]}};
    end else if (ctrl == ST_SH) begin
      r.be         = 4'b0011 << {ea[1], 1'b0};
      r.wdata      = {2{data[15:0]}};
      r.misaligned = ea[0];
    end else if (ctrl == ST_SW) begin
      r.be         = 4'b1111;
      r.wdata      = data;
      r.misaligned = |ea;
    end
    return r;
  endfunction

endpackage

// File: rtl/store_unit_if.sv
// Store request channel plus the data-memory write port of the store unit.
interface store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              st_valid;
  logic              st_ready;
  logic [2:0]        store_control;
  logic [31:0]       rs1_val;
  logic [11:0]       imm;
  logic [31:0]       rs2_val;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic              misalign_err;
  logic [ADDR_W-1:0] misalign_addr;
  logic              busy;

  // Store unit side.
  modport slave (
    input  st_valid, store_control, rs1_val, imm, rs2_val, mem_ack,
    output st_ready, mem_req, mem_addr, mem_wdata, mem_be,
           misalign_err, misalign_addr, busy
  );

  // Decoder / memory side.
  modport master (
    output st_valid, store_control, rs1_val, imm, rs2_val, mem_ack,
    input  st_ready, mem_req, mem_addr, mem_wdata, mem_be,
           misalign_err, misalign_addr, busy
  );
endinterface

// File: rtl/store_fifo.sv
// Circular store buffer; exposes the head and the entry behind it so the
// drain logic can issue back-to-back. DEPTH must be a power of two.
module store_fifo
  import store_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  st_entry_t                din,
  input  logic                     pop,
  output st_entry_t                head,
  output st_entry_t                head_next,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  st_entry_t     slots [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count_reg;

  // Entry storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_reg <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count_reg <= count_reg + (PW + 1)'(1);
      else if (pop && !push) count_reg <= count_reg - (PW + 1)'(1);
    end
  end

  assign head      = slots[rd_ptr];
  assign head_next = slots[rd_ptr + PW'(1)];
  assign full      = (count_reg == FULL_CNT);
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
endmodule

// File: rtl/store_unit.sv
// Store engine: effective address, lane alignment, misalignment reporting,
// buffering and in-order drain to the data-memory port.
module store_unit
  import store_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input logic         clk,
  input logic         rst_n,
  store_unit_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] ea;
  align_t            al;
  logic              accept;
  logic              push;
  logic              pop;
  logic              load;
  logic              misalign_hit;
  st_entry_t         din;
  st_entry_t         head;
  st_entry_t         head_next;
  st_entry_t         load_entry;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              misalign_err;
  logic [ADDR_W-1:0] misalign_addr;

  assign ea           = bus.rs1_val[ADDR_W-1:0] + ADDR_W'($signed(bus.imm));
  assign al           = align_store(bus.store_control, ea[1:0], bus.rs2_val);
  assign accept       = bus.st_valid && !full;
  assign misalign_hit = accept && al.misaligned;
  assign push         = accept && is_store(bus.store_control) && !al.misaligned;
  assign din          = '{addr: 32'({ea[ADDR_W-1:2], 2'b00}), wdata: al.wdata, be: al.be};

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .din       (din),
    .pop       (pop),
    .head      (head),
    .head_next (head_next),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Drain control: pick what to present next and when the head retires.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    load_entry = head;
    case (state)
      IDLE: begin
        if (!empty) begin
          load       = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mem_ack) begin
          pop = 1'b1;
          // A store pushed this same cycle is not counted; it waits for IDLE.
          if (count > CW'(1)) begin
            load       = 1'b1;
            load_entry = head_next;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Drain state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Request payload registers, held stable until the entry is acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else if (load) begin
      mem_addr  <= load_entry.addr[ADDR_W-1:0];
      mem_wdata <= load_entry.wdata;
      mem_be    <= load_entry.be;
    end
  end

  // One-cycle misalignment pulse; the offending address is kept until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign_err <= misalign_hit;
      if (misalign_hit) misalign_addr <= ea;
    end
  end

  assign bus.st_ready      = !full;
  assign bus.mem_req       = (state == ISSUE);
  assign bus.mem_addr      = mem_addr;
  assign bus.mem_wdata     = mem_wdata;
  assign bus.mem_be        = mem_be;
  assign bus.misalign_err  = misalign_err;
  assign bus.misalign_addr = misalign_addr;
  assign bus.busy          = (count != '0) || (state == ISSUE);
endmodule

// File: tb/tb_store_unit.sv
// Directed and random stimulus for store_unit, checked against a queue-based
// reference model of accepted stores and the request timing rules.
`timescale 1ns/1ps
module tb_store_unit;
  import store_pkg::*;

  localparam int DEPTH  = 2;
  localparam int ADDR_W = 32;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  exp_t        q[$];
  logic        req_m = 1'b0;
  logic        err_m = 1'b0;
  logic [31:0] err_addr_m = '0;

  store_unit_if #(.ADDR_W(ADDR_W)) bus();

  store_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Architectural meaning of one store: kind 0 = dropped, 1 = queued, 2 = misaligned.
  function automatic void ref_store(input logic [2:0] c, input logic [31:0] r1,
                                    input logic [11:0] im, input logic [31:0] r2,
                                    output int kind, output logic [31:0] ea, output exp_t e);
    int off;
    ea   = r1 + 32'($signed(im));
    off  = int'(ea & 32'h3);
    kind = 0;
    e.addr  = ea & ~32'h3;
    e.wdata = '0;
    e.be    = '0;
    if (c == ST_SB) begin
      kind    = 1;
      e.be    = 4'(1 << off);
      e.wdata = {24'h0, r2[7:0]} * 32'h0101_0101;
    end else if (c == ST_SH) begin
      kind    = (off % 2 != 0) ? 2 : 1;
      e.be    = 4'(3 << off);
      e.wdata = {16'h0, r2[15:0]} * 32'h0001_0001;
    end else if (c == ST_SW) begin
      kind    = (off != 0) ? 2 : 1;
      e.be    = 4'hF;
      e.wdata = r2;
    end
  endfunction

  task automatic check_model();
    chk("req",      32'(bus.mem_req),      32'(req_m));
    chk("ready",    32'(bus.st_ready),     32'(q.size() < DEPTH));
    chk("busy",     32'(bus.busy),         32'(q.size() != 0));
    chk("err",      32'(bus.misalign_err), 32'(err_m));
    chk("err_addr", bus.misalign_addr,     err_addr_m);
    if (req_m && q.size() > 0) begin
      chk("addr",  bus.mem_addr,       q[0].addr);
      chk("wdata", bus.mem_wdata,      q[0].wdata);
      chk("be",    32'(bus.mem_be),    32'(q[0].be));
    end
  endtask

  // Drive one cycle of inputs from a negedge, advance the model, then check.
  task automatic step(input logic v, input logic [2:0] c, input logic [31:0] r1,
                      input logic [11:0] im, input logic [31:0] r2, input logic a);
    int          kind;
    int          n;
    logic [31:0] ea;
    exp_t        e;
    logic        acc;
    logic        popm;
    logic        req_n;
    bus.st_valid      = v;
    bus.store_control = c;
    bus.rs1_val       = r1;
    bus.imm           = im;
    bus.rs2_val       = r2;
    bus.mem_ack       = a;
    ref_store(c, r1, im, r2, kind, ea, e);
    n    = q.size();
    acc  = v && (n < DEPTH);
    popm = req_m && a;
    if (popm)       req_n = (n - 1 > 0);
    else if (req_m) req_n = 1'b1;
    else            req_n = (n > 0);
    err_m = acc && (kind == 2);
    if (err_m) err_addr_m = ea;
    if (popm) void'(q.pop_front());
    if (acc && kind == 1) q.push_back(e);
    req_m = req_n;
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle(input logic a);
    step(1'b0, ST_NOP, 32'h0, 12'h0, 32'h0, a);
  endtask

  initial begin
    logic [2:0] c;
    logic       v;
    bus.st_valid = 1'b0; bus.store_control = ST_NOP; bus.rs1_val = '0;
    bus.imm = '0; bus.rs2_val = '0; bus.mem_ack = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_req",      32'(bus.mem_req),      32'h0);
    chk("rst_addr",     bus.mem_addr,          32'h0);
    chk("rst_wdata",    bus.mem_wdata,         32'h0);
    chk("rst_be",       32'(bus.mem_be),       32'h0);
    chk("rst_err",      32'(bus.misalign_err), 32'h0);
    chk("rst_err_addr", bus.misalign_addr,     32'h0);
    chk("rst_busy",     32'(bus.busy),         32'h0);
    chk("rst_ready",    32'(bus.st_ready),     32'h1);
    rst_n = 1'b1;

    // SB at EA[1:0]=3
    step(1'b1, ST_SB, 32'h1000, 12'h003, 32'hA5, 1'b0);
    chk("sb_no_req_yet", 32'(bus.mem_req), 32'h0);
    idle(1'b0);
    chk("sb_req",   32'(bus.mem_req), 32'h1);
    chk("sb_addr",  bus.mem_addr,     32'h1000);
    chk("sb_be",    32'(bus.mem_be),  32'h8);
    chk("sb_wdata", bus.mem_wdata,    32'hA5A5_A5A5);
    idle(1'b1);
    chk("sb_done", 32'(bus.mem_req), 32'h0);

    // SH with negative offset
    step(1'b1, ST_SH, 32'h2000, 12'hFFE, 32'h1234, 1'b0);
    idle(1'b0);
    chk("sh_addr",  bus.mem_addr,    32'h1FFC);
    chk("sh_be",    32'(bus.mem_be), 32'hC);
    chk("sh_wdata", bus.mem_wdata,   32'h1234_1234);
    idle(1'b1);

    // Misaligned SW
    step(1'b1, ST_SW, 32'h100, 12'h002, 32'hDEAD_BEEF, 1'b0);
    chk("mis_err",   32'(bus.misalign_err), 32'h1);
    chk("mis_addr",  bus.misalign_addr,     32'h102);
    chk("mis_ready", 32'(bus.st_ready),     32'h1);
    idle(1'b0);
    chk("mis_pulse", 32'(bus.misalign_err), 32'h0);
    chk("mis_hold",  bus.misalign_addr,     32'h102);
    chk("mis_noreq", 32'(bus.mem_req),      32'h0);

    // Fill, back-to-back drain, third accepted after the first pop
    step(1'b1, ST_SW, 32'h3000, 12'h0, 32'h1111_1111, 1'b0);
    step(1'b1, ST_SW, 32'h3004, 12'h0, 32'h2222_2222, 1'b0);
    chk("fill_ready", 32'(bus.st_ready), 32'h0);
    chk("fill_addr0", bus.mem_addr,      32'h3000);
    step(1'b1, ST_SW, 32'h3008, 12'h0, 32'h3333_3333, 1'b1);
    chk("b2b_req",   32'(bus.mem_req), 32'h1);
    chk("b2b_addr1", bus.mem_addr,     32'h3004);
    chk("b2b_wdata", bus.mem_wdata,    32'h2222_2222);
    step(1'b1, ST_SW, 32'h3008, 12'h0, 32'h3333_3333, 1'b1);
    chk("third_busy", 32'(bus.busy), 32'h1);
    idle(1'b0);
    chk("third_addr", bus.mem_addr, 32'h3008);
    idle(1'b1);

    // NOP and an undefined code are dropped silently
    step(1'b1, ST_NOP, 32'h5000, 12'h0, 32'h1, 1'b0);
    chk("nop_busy", 32'(bus.busy), 32'h0);
    step(1'b1, 3'b100, 32'h5001, 12'h0, 32'h1, 1'b0);
    chk("undef_err", 32'(bus.misalign_err), 32'h0);
    idle(1'b0);
    chk("nop_noreq", 32'(bus.mem_req), 32'h0);

    // Reset while a request is outstanding with two entries queued
    step(1'b1, ST_SW, 32'h4000, 12'h0, 32'hAAAA_5555, 1'b0);
    step(1'b1, ST_SW, 32'h4004, 12'h0, 32'h5555_AAAA, 1'b0);
    chk("prerst_req", 32'(bus.mem_req), 32'h1);
    bus.st_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_req",   32'(bus.mem_req),  32'h0);
    chk("midrst_busy",  32'(bus.busy),     32'h0);
    chk("midrst_ready", 32'(bus.st_ready), 32'h1);
    q.delete();
    req_m = 1'b0; err_m = 1'b0; err_addr_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle(1'b1);
    chk("postrst_req", 32'(bus.mem_req), 32'h0);

    // Random traffic with random memory back-pressure
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0: c = 3'($urandom_range(0, 7));
        1, 2, 3: c = ST_SB;
        4, 5, 6: c = ST_SH;
        default: c = ST_SW;
      endcase
      v = ($urandom_range(0, 2) != 0);
      step(v, c, $urandom, 12'($urandom), $urandom, ($urandom_range(0, 3) != 0));
    end
    repeat (4) idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
